align_accum_bank: RTL

ALIGN_ACCUM_BANK -- requirements
Module: align_accum_bank

---
 rtl/align_accum_bank.sv | 89 ++++++++
 1 files changed

// File: rtl/align_accum_bank.sv
// Bank of NCH channel registers fed by a 2-stage align/accumulate pipeline.
// Accumulates saturate to all ones and raise a sticky sat flag.
module align_accum_bank #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned NCH = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = 18'h0FFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       zero,
    input  logic                       init,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       op,
    input  logic [$clog2(NCH)-1:0]     wr_ch,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [IN_WIDTH-1:0]        d_in,
    input  logic [$clog2(NCH)-1:0]     rd_ch,
    output logic [WIDTH-1:0]           r_out,
    output logic                       sat
);
    localparam int unsigned CW = $clog2(NCH);

    logic [WIDTH-1:0] ch_q [NCH];
    logic             s1_valid;
    logic             s1_op;
    logic [CW-1:0]    s1_ch;
    logic [WIDTH-1:0] s1_data;

    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] wr_val;
    logic             wr_en;
    logic             wr_sat;
    logic             rd_ok;

    assign in_ready = !(zero | init);

    // The channel is read at the same edge it is written, so back-to-back
    // accumulates to one channel always see the previous result.
    always_comb begin
        aligned = WIDTH'(d_in) << shamt;
        wr_en   = s1_valid && (int'(s1_ch) < int'(NCH));
        cur     = wr_en ? ch_q[s1_ch] : '0;
        sum     = {1'b0, cur} + {1'b0, s1_data};
        wr_sat  = s1_op & sum[WIDTH];
        if (!s1_op) begin
            wr_val = s1_data;
        end else if (sum[WIDTH]) begin
            wr_val = '1;
        end else begin
            wr_val = sum[WIDTH-1:0];
        end
        rd_ok = int'(rd_ch) < int'(NCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) ch_q[i] <= '0;
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_ch    <= '0;
            s1_data  <= '0;
            r_out    <= '0;
            sat      <= 1'b0;
        end else begin
            r_out <= rd_ok ? ch_q[rd_ch] : '0;
            if (zero) begin
                for (int i = 0; i < int'(NCH); i++) ch_q[i] <= '0;
                s1_valid <= 1'b0;
                sat      <= 1'b0;
            end else if (init) begin
                for (int i = 0; i < int'(NCH); i++) ch_q[i] <= INIT_VAL;
                s1_valid <= 1'b0;
            end else begin
                if (wr_en) begin
                    ch_q[s1_ch] <= wr_val;
                    if (wr_sat) sat <= 1'b1;
                end
                s1_valid <= in_valid;
                s1_op    <= op;
                s1_ch    <= wr_ch;
                s1_data  <= aligned;
            end
        end
    end
endmodule
